shift_seq: RTL and testbench
============================

# shift_seq

Multi-cycle sequencer for the shared shift datapath. It accepts one operand, amount and opcode through a valid/ready handshake. It then walks the log-stage `shifter_nb` chain one stage per clock (SHFT = 1, 2, 4, 8), enabling only the stages whose amount bit is set, and presents the result through a valid/ready output. It sits between the execute-stage issue logic and the shifter stages, replacing a fully combinational barrel path with a registered one.

## Interface
- `N`, 16: operand width; must be a power of two.
- `A`, 4: amount width; equals log2(N). One `shifter_nb` stage per amount bit, stage i instantiated with SHFT = 2^i.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  high only in IDLE; accept = `in_valid & in_ready` at a rising edge.
- `in_data`  in  N  operand.
- `in_amt`  in  A  shift amount, 0..N-1.
- `in_op`  in  2  00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical.
- `out_valid`  out  1  result available; high only in DONE.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  N  result register.
- `busy`  out  1  high in SHIFT or DONE.

## Operation
- Registers: `data_q`[N], `amt_q`[A] (remaining bits), `op_q`[2], `stage_q`[log2 A], `state_q` ∈ {IDLE, SHIFT, DONE}. `out_data` is `data_q`.
- IDLE: `in_ready`=1. On accept, capture `in_data`, `in_amt` and `in_op`, and set `stage_q`=0.
  - If `in_amt`==0, go to DONE with `data_q`=`in_data`.
  - Otherwise go to SHIFT.
- SHIFT: stage `stage_q` receives `data_q`, Op=`op_q` and Cnt=`amt_q[stage_q]`. Stages not selected are bypassed.
  - At the edge: `data_q` ← stage output, `amt_q[stage_q]` ← 0, `stage_q` += 1.
  - If all `amt_q` bits above `stage_q` are zero, go to DONE. Otherwise stay in SHIFT.
- DONE: `out_valid`=1 and `out_data` is held stable. When `out_ready`=1 at an edge, go to IDLE.
- No new request is accepted in the DONE→IDLE handoff cycle, since `in_ready`=0 in DONE. Back-to-back throughput is therefore one op per (latency+1) cycles minimum.
- Arithmetic:
  - Rotates wrap bits around mod N.
  - Logical shifts fill with 0.
  - Amount is unsigned and never exceeds N-1.
  - Op semantics per stage compose exactly, so the total shift equals `in_amt`.
- Inputs are sampled only at the accept edge. Changes to `in_data`, `in_amt` or `in_op` afterwards have no effect on the op in flight.

## Timing
- Reset (`rst_n` low, asynchronous assert):
  - `state_q`=IDLE, `data_q`=0, `amt_q`=0, `op_q`=0, `stage_q`=0.
  - Outputs: `out_valid`=0, `out_data`=0x0000, `busy`=0, `in_ready`=1.
  - No accept occurs while `rst_n` is low.
- Latency, with accept at edge E0 and h = index of the highest set bit of `in_amt`:
  - `in_amt`=0: `out_valid` rises in the cycle after E0.
  - Otherwise: `out_valid` rises after edge E0+h+1, so 1 to 4 SHIFT cycles for N=16.
- `out_valid` stays high until the edge at which `out_ready`=1. `out_valid` and `busy` fall in the cycle after that edge.
- Reset mid-SHIFT or mid-DONE: immediate return to IDLE. The pending result is discarded and never presented.
- `in_valid` asserted while busy: ignored and not queued. The requester must hold `in_valid` until it sees `in_ready`.

## Test plan
- Reset with `in_valid`=1, `in_data`=0xFFFF: `out_valid`=0, `out_data`=0x0000, `in_ready`=1 throughout; after release, `out_valid` stays 0 until an accept occurs.
- ROL: `in_data`=0x8001, amt=1, op=00 → `out_data`=0x0003, `out_valid` one cycle after the SHIFT edge (accept + 1 SHIFT cycle).
- SLL: `in_data`=0x00FF, amt=12 (h=3), op=01 → `out_data`=0xF000, `out_valid` after E0+4; `busy`=1 from E0 until the cycle after the handshake completes.
- ROR and SRL:
  - 0x1234, amt=4, op=10 → 0x4123.
  - 0x8000, amt=15, op=11 → 0x0001 after 4 SHIFT cycles.
- Zero amount with backpressure: 0xBEEF, amt=0, op=01, `out_ready`=0 for 5 cycles.
  - `out_data`=0xBEEF held and `in_ready`=0.
  - A second `in_valid` (0x1111) is not accepted.
  - After `out_ready`=1: IDLE, then 0x1111 is accepted.
- Reset mid-op: 0x00FF, amt=8, op=01; pulse `rst_n` low for one cycle during SHIFT → `out_valid` never asserts for that op, `out_data`=0x0000, `in_ready`=1 the cycle after release.

Source files
------------

// File: rtl/shift_seq_if.sv
// Request/response bundle between the issue logic and the shift sequencer.
// The requester drives operand, amount and opcode; the sequencer returns the result.
interface shift_seq_if #(
   parameter int N = 16,
   parameter int A = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic [A-1:0] in_amt;
   logic [1:0]   in_op;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   // Sequencer side
   modport slave (
      input  in_valid, in_data, in_amt, in_op, out_ready,
      output in_ready, out_valid, out_data
   );

   // Requester / consumer side
   modport master (
      output in_valid, in_data, in_amt, in_op, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: one log-stage per clock, only stages whose
// amount bit is set change the data, result held until the consumer takes it.

// One fixed-distance stage of the log shifter; passes data through when cnt is low.
module shifter_nb #(
   parameter int N    = 16,
   parameter int SHFT = 1
) (
   input  logic [N-1:0] din,
   input  logic [1:0]   op,
   input  logic         cnt,
   output logic [N-1:0] dout
);
   // Apply this stage's fixed shift/rotate or bypass it
   always_comb begin
      dout = din;
      if (cnt) begin
         case (op)
            2'b00:   dout = (din << SHFT) | (din >> (N - SHFT));
            2'b01:   dout = din << SHFT;
            2'b10:   dout = (din >> SHFT) | (din << (N - SHFT));
            2'b11:   dout = din >> SHFT;
            default: dout = din;
         endcase
      end else begin
         dout = din;
      end
   end
endmodule

module shift_seq #(
   parameter int N = 16,
   parameter int A = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   shift_seq_if.slave  bus,
   output logic        busy
);
   localparam int SW = $clog2(A);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   data_q, data_d;
   logic [A-1:0]   amt_q, amt_d;
   logic [1:0]     op_q, op_d;
   logic [SW-1:0]  stage_q, stage_d;
   logic           in_ready_q, out_valid_q, busy_q;

   logic [N-1:0]   stage_out [A];
   logic [N-1:0]   cur_out;
   logic [A-1:0]   hi_bits;

   // Only the stage addressed by stage_q may act; the rest see cnt low.
   for (genvar i = 0; i < A; i++) begin : g_stage
      shifter_nb #(
         .N    (N),
         .SHFT (1 << i)
      ) u_stage (
         .din  (data_q),
         .op   (op_q),
         .cnt  (amt_q[i] && (stage_q == SW'(i))),
         .dout (stage_out[i])
      );
   end

   assign cur_out = stage_out[stage_q];
   // Amount bits strictly above the current stage; widened so stage A-1 + 1 does not wrap.
   assign hi_bits = amt_q >> ({1'b0, stage_q} + {{SW{1'b0}}, 1'b1});

   // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      amt_d   = amt_q;
      op_d    = op_q;
      stage_d = stage_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               data_d  = bus.in_data;
               amt_d   = bus.in_amt;
               op_d    = bus.in_op;
               stage_d = {SW{1'b0}};
               if (bus.in_amt == {A{1'b0}}) begin
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            data_d          = cur_out;
            amt_d[stage_q]  = 1'b0;
            stage_d         = stage_q + {{(SW-1){1'b0}}, 1'b1};
            if (hi_bits == {A{1'b0}}) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and decoded handshake flags, all registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= {N{1'b0}};
         amt_q       <= {A{1'b0}};
         op_q        <= 2'b00;
         stage_q     <= {SW{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         amt_q       <= amt_d;
         op_q        <= op_d;
         stage_q     <= stage_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d == SHIFT) || (state_d == DONE);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = data_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: hand-computed results, latency and handshake checks.
module tb_shift_seq;
   logic clk;
   logic rst_n;
   logic busy;
   int   n_checks;
   int   n_fails;

   shift_seq_if #(.N(16), .A(4)) bus ();

   shift_seq #(.N(16), .A(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Issue one op, check busy, latency, result, then drain it and check the return to IDLE.
   task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] amt,
                         input logic [1:0] op, input logic [15:0] expd, input int exp_lat);
      int lat;
      @(negedge clk);
      check({tag, "_rdy_before"}, {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_amt   = amt;
      bus.in_op    = op;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 16'hDEAD;
      bus.in_amt   = 4'hF;
      bus.in_op    = 2'b11;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, expd});
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_vld_clr"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
      check({tag, "_rdy_after"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   // Main directed sequence
   initial begin
      logic seen_valid;
      n_checks      = 0;
      n_fails       = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'hFFFF;
      bus.in_amt    = 4'd3;
      bus.in_op     = 2'b00;
      bus.out_ready = 1'b0;

      // Reset held with a request present
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_vld", {31'd0, bus.out_valid}, 32'd0);
         check("rst_data", {16'd0, bus.out_data}, 32'h0000);
         check("rst_rdy", {31'd0, bus.in_ready}, 32'd1);
         check("rst_busy", {31'd0, busy}, 32'd0);
      end
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_vld", {31'd0, bus.out_valid}, 32'd0);
      end

      // Directed ops: tag, data, amt, op, expected, expected latency (h+1, or 0 for amt 0)
      run_op("rol1",   16'h8001, 4'd1,  2'b00, 16'h0003, 1);
      run_op("sll12",  16'h00FF, 4'd12, 2'b01, 16'hF000, 4);
      run_op("ror4",   16'h1234, 4'd4,  2'b10, 16'h4123, 3);
      run_op("srl15",  16'h8000, 4'd15, 2'b11, 16'h0001, 4);
      run_op("rol5",   16'h1234, 4'd5,  2'b00, 16'h4682, 3);
      run_op("ror1",   16'h0001, 4'd1,  2'b10, 16'h8000, 1);
      run_op("sll3",   16'hF00F, 4'd3,  2'b01, 16'h8078, 2);
      run_op("srl6",   16'hABCD, 4'd6,  2'b11, 16'h02AF, 3);
      run_op("rol15",  16'h0003, 4'd15, 2'b00, 16'h8001, 4);

      // Zero amount with backpressure and a competing request
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hBEEF;
      bus.in_amt   = 4'd0;
      bus.in_op    = 2'b01;
      @(posedge clk);
      @(negedge clk);
      bus.in_data  = 16'h1111;
      bus.in_amt   = 4'd0;
      bus.in_op    = 2'b01;
      check("z_vld", {31'd0, bus.out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("z_hold_data", {16'd0, bus.out_data}, 32'h0000BEEF);
         check("z_hold_rdy", {31'd0, bus.in_ready}, 32'd0);
         check("z_hold_vld", {31'd0, bus.out_valid}, 32'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("z_idle_rdy", {31'd0, bus.in_ready}, 32'd1);
      check("z_idle_vld", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("z2_vld", {31'd0, bus.out_valid}, 32'd1);
      check("z2_data", {16'd0, bus.out_data}, 32'h00001111);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("z2_drain", {31'd0, bus.out_valid}, 32'd0);

      // Reset pulse during SHIFT discards the op
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h00FF;
      bus.in_amt   = 4'd8;
      bus.in_op    = 2'b01;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("mid_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_data", {16'd0, bus.out_data}, 32'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rdy", {31'd0, bus.in_ready}, 32'd1);
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen_valid = seen_valid | bus.out_valid;
      end
      check("mid_no_vld", {31'd0, seen_valid}, 32'd0);
      check("mid_data", {16'd0, bus.out_data}, 32'h0000);

      // Machine still usable after the aborted op
      run_op("after", 16'h0F0F, 4'd4, 2'b11, 16'h00F0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
